// File: rtl/raster_pixel_writer.sv
// ---------------------------------------------------------------------------
// raster_pixel_writer
//
// Last stage of the rasterizer/shader pipeline. Shaded pixels (screen x/y and
// 10-bit RGB) arrive on a valid/ready handshake and wait in a small FIFO. Each
// pixel becomes one 32-bit word write into the linear framebuffer over the GPU
// main external memory interface. Pixels outside the screen are discarded
// without any bus traffic. The FIFO lets the rasterizer keep running while
// the memory side stalls on acknowledge.
//
// Parameters
//   FB_BASE     byte address of pixel (0,0)
//   FB_WIDTH    pixels per row, also the row stride in words
//   FB_HEIGHT   number of rows
//   FIFO_DEPTH  pixel FIFO entries (power of two, >= 2)
//
// Ports
//   pll_clock                                 in   sole clock, rising edge
//   sys_reset_n                               in   async active-low reset
//   pix_valid / pix_ready                     in/out pixel handshake
//   pix_x, pix_y                              in   screen coordinates
//   pix_r, pix_g, pix_b                       in   colour channels
//   gpu_main_external_interface_address       out  byte address
//   gpu_main_external_interface_write         out  write request
//   gpu_main_external_interface_read          out  constant 0
//   gpu_main_external_interface_byte_enable   out  4'hF while writing
//   gpu_main_external_interface_write_data    out  {2'b00, r, g, b}
//   gpu_main_external_interface_acknowledge   in   write accepted
//   busy                                      out  FIFO non-empty or FSM active
//   stat_written, stat_dropped                out  event counters
//
// Build option
//   RASTER_WRITER_STATS_EN : when defined, adds the stat_written and
//   stat_dropped ports and their wrapping 32-bit counters.
//
// FSM states
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for a pixel; pops the FIFO head when one is present
//   S_ADDR  | bounds check; launches the write or drops the pixel
//   S_WRITE | write request held on the bus until acknowledge
// ---------------------------------------------------------------------------
module raster_pixel_writer #(
    parameter logic [31:0] FB_BASE    = 32'h32000000,
    parameter int unsigned FB_WIDTH   = 800,
    parameter int unsigned FB_HEIGHT  = 600,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        pll_clock,
    input  logic        sys_reset_n,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic [9:0]  pix_r,
    input  logic [9:0]  pix_g,
    input  logic [9:0]  pix_b,
    output logic [31:0] gpu_main_external_interface_address,
    output logic        gpu_main_external_interface_write,
    output logic        gpu_main_external_interface_read,
    output logic [3:0]  gpu_main_external_interface_byte_enable,
    output logic [31:0] gpu_main_external_interface_write_data,
    input  logic        gpu_main_external_interface_acknowledge,
    output logic        busy
`ifdef RASTER_WRITER_STATS_EN
    ,
    output logic [31:0] stat_written,
    output logic [31:0] stat_dropped
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Pixel FIFO
    // -----------------------------------------------------------------------
    pixel_t          r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    pixel_t          w_push_pix;
    pixel_t          w_head;

    // Ready depends only on the registered occupancy, so a full FIFO refuses
    // a pixel even in a cycle where the FSM pops. Reset gates it low so the
    // upstream never sees ready while the block is held in reset.
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign pix_ready = sys_reset_n && !w_full;
    assign w_push    = pix_valid && pix_ready;

    assign w_push_pix = '{x: pix_x, y: pix_y, r: pix_r, g: pix_g, b: pix_b};
    assign w_head     = r_mem[r_rd_ptr];

    // Storage is not reset: the occupancy count decides what is valid.
    always_ff @(posedge pll_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_pix;
        end
    end

    always_ff @(posedge pll_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Write sequencer
    // -----------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_launch;
    logic            w_drop;
    logic            w_done;

    logic [9:0]      r_x;
    logic [9:0]      r_y;
    logic [9:0]      r_r;
    logic [9:0]      r_g;
    logic [9:0]      r_b;

    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic            r_write;
    logic [3:0]      r_be;

    logic            w_off_screen;
    logic [31:0]     w_pix_index;
    logic [31:0]     w_addr;

    assign w_off_screen = (32'(r_x) >= FB_WIDTH) || (32'(r_y) >= FB_HEIGHT);

    // Linear pixel index and byte address, all modulo 2^32.
    assign w_pix_index = (32'(r_y) * FB_WIDTH) + 32'(r_x);
    assign w_addr      = FB_BASE + (w_pix_index << 2);

    always_ff @(posedge pll_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_launch    = 1'b0;
        w_drop      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (w_off_screen) begin
                    w_drop      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (gpu_main_external_interface_acknowledge) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Pixel holding registers and bus registers. Address and data keep their
    // last value after a write completes; only write/byte_enable return to 0.
    always_ff @(posedge pll_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_r     <= '0;
            r_g     <= '0;
            r_b     <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_be    <= '0;
        end else begin
            if (w_pop) begin
                r_x <= w_head.x;
                r_y <= w_head.y;
                r_r <= w_head.r;
                r_g <= w_head.g;
                r_b <= w_head.b;
            end
            if (w_launch) begin
                r_addr  <= w_addr;
                r_wdata <= {2'b00, r_r, r_g, r_b};
                r_write <= 1'b1;
                r_be    <= 4'hF;
            end
            if (w_done) begin
                r_write <= 1'b0;
                r_be    <= 4'h0;
            end
        end
    end

    assign gpu_main_external_interface_address     = r_addr;
    assign gpu_main_external_interface_write_data  = r_wdata;
    assign gpu_main_external_interface_write       = r_write;
    assign gpu_main_external_interface_byte_enable = r_be;
    assign gpu_main_external_interface_read        = 1'b0;

    assign busy = !w_empty || (r_state != S_IDLE);

`ifdef RASTER_WRITER_STATS_EN
    // -----------------------------------------------------------------------
    // Event counters, free-running and wrapping at 2^32
    // -----------------------------------------------------------------------
    logic [31:0] r_stat_written;
    logic [31:0] r_stat_dropped;

    always_ff @(posedge pll_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_stat_written <= '0;
            r_stat_dropped <= '0;
        end else begin
            if (w_done) begin
                r_stat_written <= r_stat_written + 32'd1;
            end
            if (w_drop) begin
                r_stat_dropped <= r_stat_dropped + 32'd1;
            end
        end
    end

    assign stat_written = r_stat_written;
    assign stat_dropped = r_stat_dropped;
`endif

endmodule
